// File: rtl/vga_timing_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_if : raster timing bundle (coordinates, strobes, sync, blank)   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface vga_timing_if;
  logic        pix_en;
  logic [11:0] hdata;
  logic [11:0] vdata;
  logic        valid;
  logic        line_start;
  logic        frame_start;
  logic        valid_out;
  logic        hsync;
  logic        vsync;

  modport master (
    output pix_en, hdata, vdata, valid, line_start, frame_start,
           valid_out, hsync, vsync
  );

  modport slave (
    input  pix_en, hdata, vdata, valid, line_start, frame_start,
           valid_out, hsync, vsync
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing : pixel-enable divider, H/V raster counters and delayed sync    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_timing #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [11:0]      H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0]      V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0]      H_ACT_C    = 12'(H_ACTIVE);
  localparam logic [11:0]      V_ACT_C    = 12'(V_ACTIVE);
  localparam logic [11:0]      HS_START_C = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0]      HS_END_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0]      VS_START_C = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0]      VS_END_C   = 12'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (CLK_DIV < 1 || PIPE_DELAY < 0 || (H_TOTAL - 1) > 4095 || (V_TOTAL - 1) > 4095) begin : g_bad_params
      $error("vga_timing: illegal parameter set");
    end
  endgenerate

  logic [DIV_W-1:0] div_q, div_d;
  logic [11:0]      hc_q, hc_d;
  logic [11:0]      vc_q, vc_d;
  logic [11:0]      hdata_q, vdata_q;
  logic             valid_q;
  logic             line_start_q;
  logic             frame_start_q;
  logic             hs_raw_q, vs_raw_q;
  logic             pix_tick;
  logic [2:0]       pipe_in;
  logic [2:0]       pipe_out;

  assign pix_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = pix_tick ? '0 : div_q + 1'b1;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (pix_tick) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 12'd1;
      end else begin
        hc_d = hc_q + 12'd1;
      end
    end
  end

  // Coordinates, blank and raw sync are all captured from the counters on the same tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      hdata_q       <= '0;
      vdata_q       <= '0;
      valid_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_raw_q      <= 1'b0;
      vs_raw_q      <= 1'b0;
    end else begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_tick) begin
        hdata_q       <= hc_q;
        vdata_q       <= vc_q;
        valid_q       <= (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
        hs_raw_q      <= (hc_q >= HS_START_C) && (hc_q < HS_END_C);
        vs_raw_q      <= (vc_q >= VS_START_C) && (vc_q < VS_END_C);
        line_start_q  <= (hc_q == 12'd0);
        frame_start_q <= (hc_q == 12'd0) && (vc_q == 12'd0);
      end
    end
  end

  assign pipe_in = {hs_raw_q, vs_raw_q, valid_q};

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign pipe_out = pipe_in;
    end else begin : g_delay
      logic [2:0] stage_q [PIPE_DELAY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= pipe_in;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign pipe_out = stage_q[PIPE_DELAY-1];
    end
  endgenerate

  // pix_en is gated by rst so CLK_DIV=1 still reads 0 while reset is held.
  assign vga_o.pix_en      = pix_tick & ~rst;
  assign vga_o.hdata       = hdata_q;
  assign vga_o.vdata       = vdata_q;
  assign vga_o.valid       = valid_q;
  assign vga_o.line_start  = line_start_q;
  assign vga_o.frame_start = frame_start_q;
  assign vga_o.valid_out   = pipe_out[0];
  assign vga_o.hsync       = pipe_out[2] ? SYNC_POL : ~SYNC_POL;
  assign vga_o.vsync       = pipe_out[1] ? SYNC_POL : ~SYNC_POL;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing : scoreboard bench for vga_timing (default, small, fast)     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_vga_timing;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0_a     = 0;
  int exp_q[$];

  vga_timing_if ifa ();
  vga_timing_if ifb ();
  vga_timing_if ifc ();

  vga_timing u_a (.clk(clk), .rst(rst_a), .vga_o(ifa.master));

  // Small raster: 16 x 11 pixels, 2 clk/pixel, two-stage delay -> 352-clk frame.
  vga_timing #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .PIPE_DELAY(2)
  ) u_b (.clk(clk), .rst(rst_b), .vga_o(ifb.master));

  vga_timing #(
    .CLK_DIV(1), .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) u_c (.clk(clk), .rst(rst_c), .vga_o(ifc.master));

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [30:0] got;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) step();
    got = {ifa.pix_en, ifa.hdata, ifa.vdata, ifa.valid, ifa.line_start,
           ifa.frame_start, ifa.valid_out, ifa.hsync, ifa.vsync};
    checks++;
    if (got !== {1'b0, 12'd0, 12'd0, 5'b00000, 2'b11}) begin
      failures++; $display("FAIL reset_a got=%h exp=%h", got, {1'b0, 12'd0, 12'd0, 5'b00000, 2'b11});
    end
    got = {ifb.pix_en, ifb.hdata, ifb.vdata, ifb.valid, ifb.line_start,
           ifb.frame_start, ifb.valid_out, ifb.hsync, ifb.vsync};
    checks++;
    if (got !== {1'b0, 12'd0, 12'd0, 5'b00000, 2'b11}) begin
      failures++; $display("FAIL reset_b got=%h exp=%h", got, {1'b0, 12'd0, 12'd0, 5'b00000, 2'b11});
    end
    got = {ifc.pix_en, ifc.hdata, ifc.vdata, ifc.valid, ifc.line_start,
           ifc.frame_start, ifc.valid_out, ifc.hsync, ifc.vsync};
    checks++;
    if (got !== {1'b0, 12'd0, 12'd0, 5'b00000, 2'b00}) begin
      failures++; $display("FAIL reset_c got=%h exp=%h", got, {1'b0, 12'd0, 12'd0, 5'b00000, 2'b00});
    end
  endtask

  task automatic test_startup();
    int e;
    exp_q.delete();
    exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(11);
    @(negedge clk); rst_a = 1'b0; #1; cyc++; t0_a = cyc;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) step();
      if (ifa.pix_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL startup_pix_en got=clk%0d exp=none", k);
        end else begin
          e = exp_q.pop_front();
          if (k !== e) begin failures++; $display("FAIL startup_pix_en got=clk%0d exp=clk%0d", k, e); end
        end
      end
      if (k == 4) begin
        checks++;
        if ({ifa.hdata, ifa.vdata, ifa.valid, ifa.frame_start, ifa.line_start} !== {12'd0, 12'd0, 3'b111}) begin
          failures++;
          $display("FAIL startup_first_pixel got=h%0d v%0d val%b fs%b ls%b exp=h0 v0 val1 fs1 ls1",
                   ifa.hdata, ifa.vdata, ifa.valid, ifa.frame_start, ifa.line_start);
        end
      end
      if (k == 5) begin
        checks++;
        if ({ifa.valid_out, ifa.hsync, ifa.vsync, ifa.frame_start} !== 4'b1110) begin
          failures++;
          $display("FAIL startup_delayed got=vo%b hs%b vs%b fs%b exp=vo1 hs1 vs1 fs0",
                   ifa.valid_out, ifa.hsync, ifa.vsync, ifa.frame_start);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL startup_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_line();
    int e, prev_h, max_h, stop;
    bit wrapped;
    exp_q.delete();
    exp_q.push_back(t0_a + 3204); exp_q.push_back(t0_a + 6404);
    stop = t0_a + 6410; max_h = 0; wrapped = 1'b0;
    while (cyc < stop) begin
      prev_h = int'(ifa.hdata);
      step();
      if (ifa.line_start === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL line_start got=clk%0d exp=none", cyc - t0_a);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin failures++; $display("FAIL line_start got=clk%0d exp=clk%0d", cyc - t0_a, e - t0_a); end
        end
      end
      if (int'(ifa.hdata) > max_h) max_h = int'(ifa.hdata);
      if (!wrapped && prev_h == 799 && int'(ifa.hdata) != 799) begin
        wrapped = 1'b1;
        checks++;
        if (ifa.hdata !== 12'd0 || ifa.vdata !== 12'd1) begin
          failures++; $display("FAIL line_wrap got=h%0d v%0d exp=h0 v1", ifa.hdata, ifa.vdata);
        end
      end
    end
    checks++;
    if (max_h != 799 || !wrapped) begin failures++; $display("FAIL line_max got=%0d wrapped=%0d exp=799 wrapped=1", max_h, wrapped); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL line_start_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_hsync();
    int c656, lowcnt;
    bit seen639, seen640;
    c656 = -1; seen639 = 1'b0; seen640 = 1'b0;
    for (int n = 0; n < 3400 && c656 < 0; n++) begin
      step();
      if (ifa.hdata == 12'd639 && !seen639) begin
        seen639 = 1'b1; checks++;
        if (ifa.valid !== 1'b1) begin failures++; $display("FAIL valid_at_639 got=%b exp=1", ifa.valid); end
      end
      if (ifa.hdata == 12'd640 && !seen640) begin
        seen640 = 1'b1; checks++;
        if (ifa.valid !== 1'b0) begin failures++; $display("FAIL valid_at_640 got=%b exp=0", ifa.valid); end
      end
      if (ifa.hdata == 12'd656) begin
        c656 = cyc; checks++;
        if (ifa.hsync !== 1'b1) begin failures++; $display("FAIL hsync_pre got=%b exp=1", ifa.hsync); end
      end
    end
    checks++;
    if (c656 < 0) begin
      failures++; $display("FAIL hsync_timeout got=no hdata 656 exp=hdata 656");
    end else begin
      step();
      if (ifa.hsync !== 1'b0) begin failures++; $display("FAIL hsync_fall got=%b exp=0", ifa.hsync); end
      lowcnt = 0;
      while (ifa.hsync === 1'b0 && lowcnt < 1000) begin lowcnt++; step(); end
      checks++;
      if (lowcnt != 384) begin failures++; $display("FAIL hsync_width got=%0d exp=384", lowcnt); end
    end
  endtask

  task automatic test_frame();
    int e, t0, prev_v, c7, vs_fall, vs_rise, bad;
    bit vwrap, v1, v2;
    logic prev_vs;
    exp_q.delete();
    @(negedge clk); rst_b = 1'b0; #1; cyc++; t0 = cyc;
    exp_q.push_back(t0 + 2); exp_q.push_back(t0 + 354); exp_q.push_back(t0 + 706);
    prev_v = 0; c7 = -1; vs_fall = -1; vs_rise = -1; bad = 0;
    vwrap = 1'b0; v1 = 1'b0; v2 = 1'b0; prev_vs = ifb.vsync;
    for (int k = 0; k <= 712; k++) begin
      if (k > 0) step();
      if (ifb.frame_start === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL frame_start got=clk%0d exp=none", k);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin failures++; $display("FAIL frame_start got=clk%0d exp=clk%0d", k, e - t0); end
        end
      end
      if (!vwrap && ifb.vdata == 12'd0 && prev_v != 0) begin
        vwrap = 1'b1; checks++;
        if (prev_v != 10) begin failures++; $display("FAIL vdata_wrap got=%0d->0 exp=10->0", prev_v); end
      end
      if (c7 < 0 && ifb.vdata == 12'd7) c7 = cyc;
      if (vs_fall < 0 && prev_vs === 1'b1 && ifb.vsync === 1'b0) vs_fall = cyc;
      if (vs_fall >= 0 && vs_rise < 0 && prev_vs === 1'b0 && ifb.vsync === 1'b1) vs_rise = cyc;
      if (ifb.valid_out !== v2) bad++;
      v2 = v1; v1 = ifb.valid;
      prev_v = int'(ifb.vdata); prev_vs = ifb.vsync;
    end
    checks++;
    if (exp_q.size() != 0 || !vwrap) begin failures++; $display("FAIL frame_missing got=%0d left wrap=%0d exp=0 left wrap=1", exp_q.size(), vwrap); end
    checks++;
    if (c7 < 0 || vs_fall != c7 + 2) begin failures++; $display("FAIL vsync_start got=%0d exp=%0d", vs_fall - t0, c7 + 2 - t0); end
    checks++;
    if (vs_rise - vs_fall != 64) begin failures++; $display("FAIL vsync_width got=%0d exp=64", vs_rise - vs_fall); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL valid_out_delay got=%0d mismatched clks exp=0", bad); end
  endtask

  task automatic test_midreset();
    int e;
    bit found;
    logic [30:0] got;
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      step();
      if (ifb.hdata == 12'd5 && ifb.vdata == 12'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midreset_timeout got=no (5,3) exp=(5,3)"); end
    rst_b = 1'b1;
    step(); step();
    got = {ifb.pix_en, ifb.hdata, ifb.vdata, ifb.valid, ifb.line_start,
           ifb.frame_start, ifb.valid_out, ifb.hsync, ifb.vsync};
    checks++;
    if (got !== {1'b0, 12'd0, 12'd0, 5'b00000, 2'b11}) begin
      failures++; $display("FAIL midreset_values got=%h exp=%h", got, {1'b0, 12'd0, 12'd0, 5'b00000, 2'b11});
    end
    exp_q.delete();
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(5);
    @(negedge clk); rst_b = 1'b0; #1; cyc++;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      if (ifb.pix_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL restart_pix_en got=clk%0d exp=none", k);
        end else begin
          e = exp_q.pop_front();
          if (k !== e) begin failures++; $display("FAIL restart_pix_en got=clk%0d exp=clk%0d", k, e); end
        end
      end
      if (k == 2) begin
        checks++;
        if ({ifb.hdata, ifb.vdata, ifb.valid, ifb.frame_start} !== {12'd0, 12'd0, 2'b11}) begin
          failures++; $display("FAIL restart_first got=h%0d v%0d val%b fs%b exp=h0 v0 val1 fs1",
                               ifb.hdata, ifb.vdata, ifb.valid, ifb.frame_start);
        end
      end
      if (k == 3 || k == 4) begin
        checks++;
        if (ifb.valid_out !== (k == 4)) begin
          failures++; $display("FAIL restart_valid_out clk%0d got=%b exp=%b", k, ifb.valid_out, (k == 4));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL restart_missing got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_fast();
    int t0, c656, rise, fall, bad;
    logic prev_hs;
    @(negedge clk); rst_c = 1'b0; #1; cyc++; t0 = cyc;
    c656 = -1; rise = -1; fall = -1; bad = 0; prev_hs = ifc.hsync;
    for (int k = 0; k <= 900; k++) begin
      if (k > 0) step();
      if (ifc.pix_en !== 1'b1) bad++;
      if (c656 < 0 && ifc.hdata == 12'd656) c656 = cyc;
      if (rise < 0 && prev_hs === 1'b0 && ifc.hsync === 1'b1) rise = cyc;
      if (rise >= 0 && fall < 0 && prev_hs === 1'b1 && ifc.hsync === 1'b0) fall = cyc;
      prev_hs = ifc.hsync;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL fast_pix_en got=%0d low clks exp=0", bad); end
    checks++;
    if (c656 != t0 + 657 || rise != c656) begin
      failures++; $display("FAIL fast_hsync_align got=rise%0d h656_at%0d exp=both 657", rise - t0, c656 - t0);
    end
    checks++;
    if (fall - rise != 96) begin failures++; $display("FAIL fast_hsync_width got=%0d exp=96", fall - rise); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_startup();
    test_line();
    test_hsync();
    test_frame();
    test_midreset();
    test_fast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
